// File: rtl/unknown_protocol_pkg.sv
// ----------------------------------------------------------------------------
// unknown_protocol_pkg
// Definitions shared by the frame-period counter and the frame serializer:
//   - DEFAULT_FRAME_WIDTH : frame length in bits (also the counter period)
//   - state_t / ST_*      : serializer FSM encoding
//   - cnt_width()         : width of a counter that spans 0 .. w-1
// ----------------------------------------------------------------------------
package unknown_protocol_pkg;

   localparam int unsigned DEFAULT_FRAME_WIDTH = 72;

   // Serializer FSM state encoding
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/frame_period_counter.sv
// ----------------------------------------------------------------------------
// frame_period_counter
// Free-running modulo-PERIOD counter. Emits a one-cycle terminal-count strobe
// every PERIOD cycles; this strobe is the frame_tick of the serializer.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous, active-low reset (count returns to 0)
//   o_tick  : high for one cycle while the count equals PERIOD-1
// ----------------------------------------------------------------------------
module frame_period_counter
   import unknown_protocol_pkg::*;
#(
   parameter int unsigned PERIOD = DEFAULT_FRAME_WIDTH
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   localparam int unsigned CW = cnt_width(PERIOD);
   localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == LAST_CNT);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = w_last;

endmodule

// File: rtl/frame_serializer.sv
// ----------------------------------------------------------------------------
// frame_serializer
// Accepts parallel frames over valid/ready into a one-entry holding buffer and
// shifts them out MSB-first, one bit per clock. Frames are moved from the
// buffer into the shift register only on frame_tick, so a tick on the last bit
// of a frame with a buffered successor gives a gap-free serial stream.
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high reset
//   frame_tick  : one-cycle frame-boundary strobe from the period counter
//   data_in     : parallel frame, bit FRAME_WIDTH-1 sent first
//   data_valid  : data_in is valid
//   data_ready  : holding buffer is empty and can accept a frame
//   serial_out  : serial bit stream (IDLE_LEVEL when not shifting)
//   serial_en   : serial_out carries frame data this cycle
//   frame_start : high with the first (MSB) bit of each frame
//   underrun    : pulse, a tick found the holding buffer empty
//   sync_err    : pulse, a tick arrived before the current frame finished
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module frame_serializer
   import unknown_protocol_pkg::*;
#(
   parameter int unsigned FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
   parameter logic        IDLE_LEVEL  = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   frame_tick,
   input  logic [FRAME_WIDTH-1:0] data_in,
   input  logic                   data_valid,
   output logic                   data_ready,
   output logic                   serial_out,
   output logic                   serial_en,
   output logic                   frame_start,
   output logic                   underrun,
   output logic                   sync_err
);

   localparam int unsigned CW = cnt_width(FRAME_WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_WIDTH - 1);

   if (FRAME_WIDTH < 2) begin : g_width_check
      $error("frame_serializer: FRAME_WIDTH must be at least 2");
   end

   // Registered state
   state_t                 r_state;
   logic                   r_hold_full;
   logic [FRAME_WIDTH-1:0] r_hold_data;
   logic [FRAME_WIDTH-1:0] r_shift;
   logic [CW-1:0]          r_bit_cnt;
   logic                   r_data_ready;
   logic                   r_serial_out;
   logic                   r_serial_en;
   logic                   r_frame_start;
   logic                   r_underrun;
   logic                   r_sync_err;

   // Next-state values
   state_t                 w_state_d;
   logic                   w_hold_full_d;
   logic [FRAME_WIDTH-1:0] w_hold_data_d;
   logic [FRAME_WIDTH-1:0] w_shift_d;
   logic [CW-1:0]          w_bit_cnt_d;
   logic                   w_frame_start_d;
   logic                   w_underrun_d;
   logic                   w_sync_err_d;
   logic                   w_last;

   // r_shift[MSB] is the bit on the line while in SHIFT; r_bit_cnt is its index.
   assign w_last = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_CNT);

   always_comb begin
      w_state_d       = r_state;
      w_hold_full_d   = r_hold_full;
      w_hold_data_d   = r_hold_data;
      w_shift_d       = r_shift;
      w_bit_cnt_d     = r_bit_cnt;
      w_frame_start_d = 1'b0;
      w_underrun_d    = 1'b0;
      w_sync_err_d    = 1'b0;

      // Accept only into an empty buffer; a load below only happens when the
      // buffer is full, so the two never collide.
      if (data_valid && !r_hold_full) begin
         w_hold_full_d = 1'b1;
         w_hold_data_d = data_in;
      end

      if (r_state == ST_SHIFT) begin
         if (frame_tick) begin
            // Early tick aborts the frame; the tick is then handled below.
            if (!w_last) begin
               w_sync_err_d = 1'b1;
            end
         end else if (w_last) begin
            w_state_d = ST_IDLE;
         end else begin
            w_shift_d   = {r_shift[FRAME_WIDTH-2:0], 1'b0};
            w_bit_cnt_d = r_bit_cnt + CW'(1);
         end
      end

      // Tick handling is identical from IDLE, from the last bit and after an
      // abort: reload from the buffer, or flag an underrun and go idle.
      if (frame_tick) begin
         if (r_hold_full) begin
            w_state_d       = ST_SHIFT;
            w_shift_d       = r_hold_data;
            w_bit_cnt_d     = '0;
            w_hold_full_d   = 1'b0;
            w_frame_start_d = 1'b1;
         end else begin
            w_state_d    = ST_IDLE;
            w_underrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_hold_full   <= 1'b0;
         r_hold_data   <= '0;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_data_ready  <= 1'b1;
         r_serial_out  <= IDLE_LEVEL;
         r_serial_en   <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
         r_sync_err    <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_hold_full   <= w_hold_full_d;
         r_hold_data   <= w_hold_data_d;
         r_shift       <= w_shift_d;
         r_bit_cnt     <= w_bit_cnt_d;
         r_data_ready  <= !w_hold_full_d;
         r_serial_out  <= (w_state_d == ST_SHIFT) ? w_shift_d[FRAME_WIDTH-1] : IDLE_LEVEL;
         r_serial_en   <= (w_state_d == ST_SHIFT);
         r_frame_start <= w_frame_start_d;
         r_underrun    <= w_underrun_d;
         r_sync_err    <= w_sync_err_d;
      end
   end

   assign data_ready  = r_data_ready;
   assign serial_out  = r_serial_out;
   assign serial_en   = r_serial_en;
   assign frame_start = r_frame_start;
   assign underrun    = r_underrun;
   assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_frame_serializer.sv
// ----------------------------------------------------------------------------
// tb_frame_serializer
// Directed bench: a 72-bit serializer (ticks either manual or from the period
// counter) and an 8-bit serializer (manual ticks). Inputs change and outputs
// are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_frame_serializer;

   logic        clk;
   logic        reset;

   // 72-bit instance
   logic        tick72_man;
   logic        tick72;
   logic        use_cnt;
   logic        cnt_clr;
   logic        cnt_rst_n;
   logic        cnt_tick;
   logic [71:0] data72;
   logic        valid72;
   logic        ready72;
   logic        out72;
   logic        en72;
   logic        start72;
   logic        under72;
   logic        sync72;

   // 8-bit instance
   logic        tick8;
   logic [7:0]  data8;
   logic        valid8;
   logic        ready8;
   logic        out8;
   logic        en8;
   logic        start8;
   logic        under8;
   logic        sync8;

   int          total;
   int          bad;

   logic [71:0]  got72;
   logic [143:0] got144;
   logic [7:0]   got8;
   logic [2:0]   b3;
   int           en_cnt;
   int           start_cnt;
   int           flag_cnt;
   int           second_start;
   logic         found;

   localparam logic [71:0] FRAME_S  = 72'hA5_0000_0000_0000_00FF;
   localparam logic [71:0] FRAME_A  = 72'h12_3456_789A_BCDE_F012;
   localparam logic [71:0] FRAME_B  = 72'hFE_DCBA_9876_5432_10AB;
   logic [7:0] bp_frames [10] = '{8'h03, 8'h28, 8'h4D, 8'h72, 8'h97,
                                  8'hBC, 8'hE1, 8'h06, 8'h2B, 8'h50};

   // The counter has an active-low reset; cnt_clr holds it at zero when unused.
   assign cnt_rst_n = !(reset || cnt_clr);
   assign tick72    = use_cnt ? cnt_tick : tick72_man;

   frame_period_counter #(
      .PERIOD (72)
   ) u_cnt (
      .i_clk   (clk),
      .i_rst_n (cnt_rst_n),
      .o_tick  (cnt_tick)
   );

   frame_serializer #(
      .FRAME_WIDTH (72),
      .IDLE_LEVEL  (1'b0)
   ) u_dut72 (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (tick72),
      .data_in     (data72),
      .data_valid  (valid72),
      .data_ready  (ready72),
      .serial_out  (out72),
      .serial_en   (en72),
      .frame_start (start72),
      .underrun    (under72),
      .sync_err    (sync72)
   );

   frame_serializer #(
      .FRAME_WIDTH (8),
      .IDLE_LEVEL  (1'b0)
   ) u_dut8 (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (tick8),
      .data_in     (data8),
      .data_valid  (valid8),
      .data_ready  (ready8),
      .serial_out  (out8),
      .serial_en   (en8),
      .frame_start (start8),
      .underrun    (under8),
      .sync_err    (sync8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      tick72_man = 1'b0; use_cnt = 1'b0; cnt_clr = 1'b1;
      data72 = '0; valid72 = 1'b0;
      tick8 = 1'b0; data8 = '0; valid8 = 1'b0;

      // ---------------- reset values ----------------
      step();
      check("rst_ready72", ready72, 1'b1);
      check("rst_en72", en72, 1'b0);
      check("rst_out72", out72, 1'b0);
      check("rst_start72", start72, 1'b0);
      check("rst_under72", under72, 1'b0);
      check("rst_sync72", sync72, 1'b0);
      check("rst_ready8", ready8, 1'b1);
      check("rst_en8", en8, 1'b0);
      reset = 1'b0;
      step();

      // ---------------- underrun right after reset (72) ----------------
      tick72_man = 1'b1;
      step();
      tick72_man = 1'b0;
      check("un72_pulse", under72, 1'b1);
      check("un72_en", en72, 1'b0);
      check("un72_out", out72, 1'b0);
      check("un72_sync", sync72, 1'b0);
      step();
      check("un72_single", under72, 1'b0);

      // ---------------- single frame (72) ----------------
      data72 = FRAME_S; valid72 = 1'b1;
      step();
      valid72 = 1'b0; data72 = 72'h0F0F_0F0F_0F0F_0F0F_0F;
      check("single_ready_drop", ready72, 1'b0);
      tick72_man = 1'b1;
      step();
      tick72_man = 1'b0;
      check("single_start", start72, 1'b1);
      check("single_ready_rise", ready72, 1'b1);
      en_cnt = 0; start_cnt = 0;
      for (int i = 0; i < 72; i++) begin
         got72[71-i] = out72;
         en_cnt += int'(en72);
         if (i > 0) start_cnt += int'(start72);
         step();
      end
      check("single_first8", got72[71:64], 8'hA5);
      check("single_last8", got72[7:0], 8'hFF);
      check("single_frame", got72, FRAME_S);
      check("single_en_cycles", en_cnt, 72);
      check("single_extra_start", start_cnt, 0);
      check("single_en_end", en72, 1'b0);
      check("single_out_end", out72, 1'b0);
      check("single_no_flag", under72 | sync72, 1'b0);

      // ---------------- back-to-back via period counter (72) ----------------
      data72 = FRAME_A; valid72 = 1'b1;
      step();
      valid72 = 1'b0;
      use_cnt = 1'b1; cnt_clr = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         if (start72) found = 1'b1;
         else step();
      end
      check("b2b_first_tick", found, 1'b1);
      en_cnt = 0; start_cnt = 0; flag_cnt = 0; second_start = -1;
      for (int i = 0; i < 144; i++) begin
         got144[143-i] = out72;
         en_cnt   += int'(en72);
         start_cnt += int'(start72);
         flag_cnt += int'(under72) + int'(sync72);
         if (start72 && i != 0) second_start = i;
         if (i == 0) begin
            valid72 = 1'b1; data72 = FRAME_B;
         end
         if (i == 1) valid72 = 1'b0;
         step();
      end
      check("b2b_frame_a", got144[143:72], FRAME_A);
      check("b2b_frame_b", got144[71:0], FRAME_B);
      check("b2b_en_cycles", en_cnt, 144);
      check("b2b_starts", start_cnt, 2);
      check("b2b_second_start", second_start, 72);
      check("b2b_flags", flag_cnt, 0);
      // The third counter tick lands on B's last bit with nothing buffered.
      check("b2b_tail_underrun", under72, 1'b1);
      check("b2b_tail_en", en72, 1'b0);
      use_cnt = 1'b0; cnt_clr = 1'b1;
      pulse_reset();

      // ---------------- accept + tick with empty buffer (8) ----------------
      tick8 = 1'b1; valid8 = 1'b1; data8 = 8'hC3;
      step();
      tick8 = 1'b0; valid8 = 1'b0; data8 = 8'h00;
      check("c3_underrun", under8, 1'b1);
      check("c3_en", en8, 1'b0);
      check("c3_out", out8, 1'b0);
      check("c3_buffered", ready8, 1'b0);
      step(); step(); step();
      check("c3_waits", en8, 1'b0);
      tick8 = 1'b1;
      step();
      tick8 = 1'b0;
      check("c3_start", start8, 1'b1);
      for (int j = 0; j < 8; j++) begin
         got8[7-j] = out8;
         step();
      end
      check("c3_bits", got8, 8'hC3);
      check("c3_en_end", en8, 1'b0);
      pulse_reset();

      // ---------------- sync error (8) ----------------
      valid8 = 1'b1; data8 = 8'hB4;
      step();
      valid8 = 1'b0;
      tick8 = 1'b1;
      step();
      tick8 = 1'b0;
      b3[2] = out8;
      valid8 = 1'b1; data8 = 8'h6D;
      step();
      valid8 = 1'b0;
      b3[1] = out8;
      step();
      b3[0] = out8;
      tick8 = 1'b1;
      step();
      tick8 = 1'b0;
      check("sync_truncated_bits", b3, 3'b101);
      check("sync_pulse", sync8, 1'b1);
      check("sync_no_underrun", under8, 1'b0);
      check("sync_restart", start8, 1'b1);
      for (int j = 0; j < 8; j++) begin
         got8[7-j] = out8;
         if (j == 1) check("sync_one_cycle", sync8, 1'b0);
         step();
      end
      check("sync_second_frame", got8, 8'h6D);
      check("sync_en_end", en8, 1'b0);
      check("sync_no_tail_flag", under8 | sync8, 1'b0);
      pulse_reset();

      // ---------------- backpressure, 10 frames (8) ----------------
      valid8 = 1'b1; data8 = bp_frames[0];
      step();
      check("bp_ready_drop0", ready8, 1'b0);
      tick8 = 1'b1;
      step();
      en_cnt = 0; flag_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick8 = 1'b0;
         check("bp_start", start8, 1'b1);
         check("bp_ready_rise", ready8, 1'b1);
         if (k < 9) data8 = bp_frames[k+1];
         else valid8 = 1'b0;
         for (int j = 0; j < 8; j++) begin
            got8[7-j] = out8;
            en_cnt   += int'(en8);
            flag_cnt += int'(under8) + int'(sync8);
            if (j == 1 && k < 9) check("bp_ready_drop", ready8, 1'b0);
            if (j == 7 && k < 9) tick8 = 1'b1;
            step();
         end
         check("bp_frame", got8, bp_frames[k]);
      end
      check("bp_en_cycles", en_cnt, 80);
      check("bp_flags", flag_cnt, 0);
      check("bp_end_idle", en8, 1'b0);
      check("bp_end_ready", ready8, 1'b1);

      // ---------------- reset mid-frame (72) ----------------
      data72 = '1; valid72 = 1'b1;
      step();
      valid72 = 1'b0;
      tick72_man = 1'b1;
      step();
      tick72_man = 1'b0;
      repeat (30) step();
      check("mid_bit30_en", en72, 1'b1);
      check("mid_bit30_out", out72, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_async_en", en72, 1'b0);
      check("mid_async_out", out72, 1'b0);
      check("mid_async_ready", ready72, 1'b1);
      check("mid_async_start", start72, 1'b0);
      step();
      reset = 1'b0;
      step();
      tick72_man = 1'b1;
      step();
      tick72_man = 1'b0;
      check("mid_underrun", under72, 1'b1);
      check("mid_no_resume_en", en72, 1'b0);
      check("mid_no_resume_out", out72, 1'b0);
      en_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         en_cnt += int'(en72);
         step();
      end
      check("mid_no_residual", en_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
